// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator: pixel/line counters plus sync and
// blanking flags, all registered from next-state counters so they never skew.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_start
);

    localparam logic [10:0] H_TOTAL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_TOTAL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_hcount, r_vcount;
    logic        r_hsync, r_vsync, r_hblnk, r_vblnk, r_frame_start;

    logic        w_h_last, w_v_last;
    logic [10:0] w_hcount_nxt, w_vcount_nxt;

    always_comb begin
        w_h_last     = (r_hcount == H_TOTAL - 11'd1);
        w_v_last     = (r_vcount == V_TOTAL - 11'd1);
        w_hcount_nxt = w_h_last ? 11'd0 : r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (w_h_last)
            w_vcount_nxt = w_v_last ? 11'd0 : r_vcount + 11'd1;
    end

    // Flags derive from the next-state counters so they line up with the
    // counter values shown in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hblnk       <= (w_hcount_nxt >= H_ACT);
            r_vblnk       <= (w_vcount_nxt >= V_ACT);
            r_hsync       <= ((w_hcount_nxt >= HS_START) && (w_hcount_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= ((w_vcount_nxt >= VS_START) && (w_vcount_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= w_h_last && w_v_last;
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign frame_start = r_frame_start;

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Free-running VGA raster timing generator; the first stage of the SkyHop video pipeline, directly upstream of the background/sprite drawing stages.
- Produces pixel/line counters, sync pulses and blanking flags for the SkyHop top level, which forwards them as hs/vs alongside r/g/b.
- Default geometry is 800x600 @ 60 Hz with a 40 MHz pixel clock, positive sync polarity.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, sync active level (1 = active-high pulse)

Ports:
- clk  input  1  pixel clock, 40 MHz
- rst  input  1  reset, asynchronous, active-low
- hcount  output  11  current pixel index in line, 0..H_TOTAL-1
- vcount  output  11  current line index in frame, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, level SYNC_POL when active
- vsync  output  1  vertical sync, level SYNC_POL when active
- hblnk  output  1  1 when hcount >= H_ACTIVE
- vblnk  output  1  1 when vcount >= V_ACTIVE
- frame_start  output  1  one-cycle pulse on the cycle the counters show (0,0) after a wrap

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- All outputs are flops clocked on the rising clk edge. No combinational path from inputs to outputs.
- Reset state (rst low, asynchronous, takes effect immediately):
  - hcount = 0, vcount = 0, hblnk = 0, vblnk = 0, frame_start = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
- Reset can be asserted at any point in a frame. On release, counting restarts from (0,0) on the first rising edge.
- Counters:
  - hcount increments by 1 per clock and wraps H_TOTAL-1 -> 0.
  - vcount increments by 1 only on the cycle hcount wraps, and wraps V_TOTAL-1 -> 0 on that same cycle.
- Zero skew: every flag is registered from the next-state counter values, so in any cycle all flags are consistent with the hcount/vcount shown in that same cycle.
  - hblnk = (hcount >= H_ACTIVE)
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967
  - vblnk = (vcount >= V_ACTIVE)
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604, for the full duration of those lines including horizontal blanking
- frame_start:
  - 1 exactly on the cycle (hcount,vcount) becomes (0,0) by wrap, i.e. once per H_TOTAL*V_TOTAL = 663168 cycles.
  - Not asserted on reset release.
- Simultaneous wrap (hcount = 1055 and vcount = 627): both counters go to 0 on the same edge, and frame_start is asserted there.
- Counter width of 11 bits covers both totals. Compare arithmetic is unsigned; no overflow is possible with the legal parameter set.

Test Plan:
- Reset/release: hold rst=0 for 5 cycles, then release -> during reset all outputs at reset values with hsync=vsync=0; the first edge after release gives hcount=1, vcount=0.
- Line timing: measure across line 0 -> hblnk rises at hcount=800, hsync high for exactly 128 cycles starting at hcount=840, hcount wraps 1055 -> 0, and vcount steps 0 -> 1 on that edge.
- Frame timing: run 2 frames at a 25 ns clock -> vsync rises at vcount=601/hcount=0, stays high 4*1056 = 4224 cycles; consecutive vsync negedges are 663168 cycles (16.579 ms) apart.
- Wrap corner: observe (1055,627) -> next cycle shows (0,0) with frame_start=1, vblnk=0, hblnk=0; frame_start is 0 on the cycle after.
- Mid-frame reset: assert rst asynchronously (between clock edges) at vcount=602 while vsync is high -> outputs go to reset values immediately without waiting for an edge, and frame_start does not pulse on release.
- Parameter override: H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, SYNC_POL=0 -> line length 800, frame 420000 cycles, hsync low for hcount 656..751.
